// File: rtl/arbiter_dispatch_pkg.sv
// Shared types and helpers for the round-robin arbiter / dispatcher family.
// rr_rot_isolate is the common "search from a start lane, take the first hit" primitive.
package arbiter_dispatch_pkg;

   localparam int unsigned RR_MAX_N = 32;

   typedef logic [$clog2(RR_MAX_N)-1:0] lane_idx_t;
   typedef logic [RR_MAX_N-1:0]         lane_vec_t;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

   // Rotates req so lane 'start' sits at bit 0, keeps the lowest set bit,
   // then rotates back. Only the low n bits take part; start is always < n.
   function automatic lane_vec_t rr_rot_isolate(input lane_vec_t   req,
                                                input int unsigned start,
                                                input int unsigned n);
      logic [2*RR_MAX_N-1:0] dbl;
      logic [2*RR_MAX_N-1:0] m64;
      lane_vec_t             mask;
      lane_vec_t             req_m;
      lane_vec_t             rot;
      lane_vec_t             iso;
      m64   = (64'd1 << n) - 64'd1;
      mask  = m64[RR_MAX_N-1:0];
      req_m = req & mask;
      if (start == 0) begin
         rot = req_m;
      end else begin
         dbl = {{RR_MAX_N{1'b0}}, req_m} | ({{RR_MAX_N{1'b0}}, req_m} << n);
         dbl = dbl >> start;
         rot = dbl[RR_MAX_N-1:0] & mask;
      end
      iso = rot & (~rot + {{(RR_MAX_N-1){1'b0}}, 1'b1});
      if (start == 0) return iso;
      dbl = {{RR_MAX_N{1'b0}}, iso} << start;
      dbl = dbl | (dbl >> n);
      return dbl[RR_MAX_N-1:0] & mask;
   endfunction

endpackage

// File: rtl/dispatch_lane_slot.sv
// One-entry output slot for a dispatch lane: a load wins over a same-cycle drain,
// and the data register only changes on load so it holds under backpressure.
module dispatch_lane_slot
   import arbiter_dispatch_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          drain,
   input  logic [DW-1:0] d,
   output logic          valid,
   output logic [DW-1:0] data
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= d;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/arbiter_round_robin_dispatch.sv
// 1-to-N round-robin dispatcher with one registered slot per lane.
// RR_DISPATCH_STRICT_EN: strict lane order 0,1,..,N-1 with no skipping (default: skip busy lanes).
module arbiter_round_robin_dispatch
   import arbiter_dispatch_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 32,
   parameter int W  = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [DW-1:0]   s_data,
   output logic [N-1:0]    m_valid,
   input  logic [N-1:0]    m_ready,
   output logic [N*DW-1:0] m_data,
   output logic            disp_fire,
   output logic [W-1:0]    disp_id
);

   logic [N-1:0] w_free;
   logic [N-1:0] w_sel;
   logic [W-1:0] w_enc;
   logic [W-1:0] r_last_lane;
   int unsigned  w_start;
   logic         w_fire;

   // A lane draining this cycle counts as free so it can be refilled back-to-back.
   assign w_free  = ~m_valid | m_ready;
   assign w_start = rr_next(32'(r_last_lane), N);

`ifdef RR_DISPATCH_STRICT_EN
   always_comb begin
      w_sel                = '0;
      w_sel[W'(w_start)]   = w_free[W'(w_start)];
   end
   assign s_ready = |w_sel;
`else
   assign w_sel   = N'(rr_rot_isolate(RR_MAX_N'(w_free), w_start, N));
   assign s_ready = |w_free;
`endif

   always_comb begin
      w_enc = '0;
      for (int i = 0; i < N; i++) begin
         w_enc = w_enc | (W'(i) & {W{w_sel[i]}});
      end
   end

   assign w_fire    = s_valid & s_ready;
   assign disp_fire = w_fire;
   assign disp_id   = w_fire ? w_enc : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_lane <= W'(N - 1);
      end else if (w_fire) begin
         r_last_lane <= w_enc;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_slot
      dispatch_lane_slot #(.DW(DW)) u_slot (
         .clk   (clk),
         .rst   (rst),
         .load  (w_fire & w_sel[g]),
         .drain (m_ready[g]),
         .d     (s_data),
         .valid (m_valid[g]),
         .data  (m_data[g*DW +: DW])
      );
   end

endmodule

// File: tb/tb_arbiter_round_robin_dispatch.sv
// Bench for arbiter_round_robin_dispatch: directed vector table, corner sequences,
// and random traffic against a lane-search reference model.
module tb_arbiter_round_robin_dispatch;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int W  = 2;
`ifdef RR_DISPATCH_STRICT_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   typedef logic [N*DW-1:0] wide_t;

   typedef struct {
      logic          do_rst;
      logic          sv;
      logic [DW-1:0] sd;
      logic [N-1:0]  mr;
      logic          exp_rdy;
      logic          exp_fire;
      logic [W-1:0]  exp_id;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            s_valid;
   logic            s_ready;
   logic [DW-1:0]   s_data;
   logic [N-1:0]    m_valid;
   logic [N-1:0]    m_ready;
   logic [N*DW-1:0] m_data;
   logic            disp_fire;
   logic [W-1:0]    disp_id;

   int n_tests = 0;
   int n_fail  = 0;

   logic          md_v [N];
   logic [DW-1:0] md_d [N];
   int            md_last;

   logic          r_rdy;
   logic          r_fire;
   logic [W-1:0]  r_id;
   vec_t          vecs [12];

   always #5 clk = ~clk;

   arbiter_round_robin_dispatch #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .disp_fire (disp_fire),
      .disp_id   (disp_id)
   );

   task automatic chk(input string name, input wide_t act, input wide_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         md_v[i] = 1'b0;
         md_d[i] = '0;
      end
      md_last = N - 1;
   endtask

   // Which lane would take a beat now: first free lane after the last one served.
   task automatic model_pick(input logic [N-1:0] mr, output logic rdy, output int lane);
      rdy  = 1'b0;
      lane = 0;
`ifdef RR_DISPATCH_STRICT_EN
      lane = (md_last + 1) % N;
      rdy  = !md_v[lane] || mr[lane];
`else
      for (int k = 1; k <= N; k++) begin
         int l;
         l = (md_last + k) % N;
         if (!rdy && (!md_v[l] || mr[l])) begin
            rdy  = 1'b1;
            lane = l;
         end
      end
`endif
   endtask

   task automatic drive(input logic sv, input logic [DW-1:0] sd, input logic [N-1:0] mr,
                        output logic a_rdy, output logic a_fire, output logic [W-1:0] a_id);
      logic         rdy;
      logic         fire;
      int           lane;
      logic [N-1:0] ev;
      wide_t        ed;
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      #1;
      model_pick(mr, rdy, lane);
      fire = sv & rdy;
      for (int i = 0; i < N; i++) begin
         ev[i]            = md_v[i];
         ed[i*DW +: DW]   = md_d[i];
      end
      chk("mdl_m_valid", wide_t'(m_valid), wide_t'(ev));
      chk("mdl_m_data", m_data, ed);
      chk("mdl_s_ready", wide_t'(s_ready), wide_t'(rdy));
      chk("mdl_disp_fire", wide_t'(disp_fire), wide_t'(fire));
      chk("mdl_disp_id", wide_t'(disp_id), fire ? wide_t'(lane) : '0);
      a_rdy  = s_ready;
      a_fire = disp_fire;
      a_id   = disp_id;
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (fire && lane == i) begin
            md_v[i] = 1'b1;
            md_d[i] = sd;
         end else if (md_v[i] && mr[i]) begin
            md_v[i] = 1'b0;
         end
      end
      if (fire) md_last = lane;
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic wide_t lane_data(input int lane);
      return wide_t'(m_data[lane*DW +: DW]);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 32'hA0, 4'hF, 1'b1, 1'b1, 2'd0};
      vecs[1]  = '{1'b0, 1'b1, 32'hA1, 4'hF, 1'b1, 1'b1, 2'd1};
      vecs[2]  = '{1'b0, 1'b1, 32'hA2, 4'hF, 1'b1, 1'b1, 2'd2};
      vecs[3]  = '{1'b0, 1'b1, 32'hA3, 4'hF, 1'b1, 1'b1, 2'd3};
      vecs[4]  = '{1'b0, 1'b1, 32'hA4, 4'hF, 1'b1, 1'b1, 2'd0};
      vecs[5]  = '{1'b0, 1'b1, 32'hA5, 4'hF, 1'b1, 1'b1, 2'd1};
      vecs[6]  = '{1'b1, 1'b1, 32'hB0, 4'h0, 1'b1, 1'b1, 2'd0};
      vecs[7]  = '{1'b0, 1'b1, 32'hB1, 4'h0, 1'b1, 1'b1, 2'd1};
      vecs[8]  = '{1'b0, 1'b1, 32'hB2, 4'h0, 1'b1, 1'b1, 2'd2};
      vecs[9]  = '{1'b0, 1'b1, 32'hB3, 4'h0, 1'b1, 1'b1, 2'd3};
      vecs[10] = '{1'b0, 1'b1, 32'hB4, 4'h0, 1'b0, 1'b0, 2'd0};
      vecs[11] = '{1'b0, 1'b1, 32'hB4, 4'b0100, !STRICT, !STRICT, STRICT ? 2'd0 : 2'd2};

      // reset state
      do_reset();
      #1;
      chk("rst_m_valid", wide_t'(m_valid), '0);
      chk("rst_m_data", m_data, '0);
      chk("rst_disp_fire", wide_t'(disp_fire), '0);
      chk("rst_disp_id", wide_t'(disp_id), '0);
      chk("rst_s_ready", wide_t'(s_ready), wide_t'(1'b1));
      @(posedge clk);
      #1;

      // directed vectors: rotation with all ready, then fill-up and stall
      for (int v = 0; v < 12; v++) begin
         if (vecs[v].do_rst) do_reset();
         drive(vecs[v].sv, vecs[v].sd, vecs[v].mr, r_rdy, r_fire, r_id);
         chk($sformatf("vec%0d_s_ready", v), wide_t'(r_rdy), wide_t'(vecs[v].exp_rdy));
         chk($sformatf("vec%0d_fire", v), wide_t'(r_fire), wide_t'(vecs[v].exp_fire));
         chk($sformatf("vec%0d_id", v), wide_t'(r_id), wide_t'(vecs[v].exp_id));
         if (vecs[v].exp_fire) begin
            chk($sformatf("vec%0d_land_data", v), lane_data(int'(vecs[v].exp_id)), wide_t'(vecs[v].sd));
            chk($sformatf("vec%0d_land_valid", v), wide_t'(m_valid[vecs[v].exp_id]), wide_t'(1'b1));
         end
      end

      // lane 1 held full with last lane 0
      do_reset();
      drive(1'b1, 32'hD0, 4'b0000, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hD1, 4'b0000, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hD2, 4'b0000, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hD3, 4'b0000, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hD4, 4'b0001, r_rdy, r_fire, r_id);
      drive(1'b0, 32'h0,  4'b1101, r_rdy, r_fire, r_id);
`ifdef RR_DISPATCH_STRICT_EN
      drive(1'b1, 32'hD5, 4'b0000, r_rdy, r_fire, r_id);
      chk("strict_stall_rdy", wide_t'(r_rdy), '0);
      drive(1'b1, 32'hD5, 4'b0010, r_rdy, r_fire, r_id);
      chk("strict_rdy", wide_t'(r_rdy), wide_t'(1'b1));
      chk("strict_id", wide_t'(r_id), wide_t'(2'd1));
      chk("strict_land", lane_data(1), wide_t'(32'hD5));
`else
      drive(1'b1, 32'hD5, 4'b0000, r_rdy, r_fire, r_id);
      chk("skip_rdy", wide_t'(r_rdy), wide_t'(1'b1));
      chk("skip_id", wide_t'(r_id), wide_t'(2'd2));
      chk("skip_land", lane_data(2), wide_t'(32'hD5));
      chk("skip_lane1_hold", lane_data(1), wide_t'(32'hD1));
`endif

      // drain and reload lane 3 in the same cycle
      do_reset();
      drive(1'b1, 32'hE0, 4'b0000, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hE1, 4'b0000, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hE2, 4'b0000, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hE3, 4'b0000, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hF0, 4'b0111, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hF1, 4'b0111, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hF2, 4'b0111, r_rdy, r_fire, r_id);
      chk("reload_old_data", lane_data(3), wide_t'(32'hE3));
      chk("reload_old_valid", wide_t'(m_valid[3]), wide_t'(1'b1));
      drive(1'b1, 32'h55, 4'b1000, r_rdy, r_fire, r_id);
      chk("reload_id", wide_t'(r_id), wide_t'(2'd3));
      chk("reload_new_data", lane_data(3), wide_t'(32'h55));
      chk("reload_new_valid", wide_t'(m_valid[3]), wide_t'(1'b1));

      // backpressure hold on lane 0
      do_reset();
      drive(1'b1, 32'h1234, 4'b0000, r_rdy, r_fire, r_id);
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 32'h0, 4'b0000, r_rdy, r_fire, r_id);
         chk("hold_data", lane_data(0), wide_t'(32'h1234));
         chk("hold_valid", wide_t'(m_valid[0]), wide_t'(1'b1));
      end

      // asynchronous reset with three slots occupied
      do_reset();
      drive(1'b1, 32'hC0, 4'b0000, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hC1, 4'b0000, r_rdy, r_fire, r_id);
      drive(1'b1, 32'hC2, 4'b0000, r_rdy, r_fire, r_id);
      chk("pre_arst_valid", wide_t'(m_valid), wide_t'(4'b0111));
      s_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_valid_now", wide_t'(m_valid), '0);
      chk("arst_data_now", m_data, '0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      drive(1'b1, 32'hC9, 4'b0000, r_rdy, r_fire, r_id);
      chk("arst_next_id", wide_t'(r_id), '0);
      chk("arst_next_fire", wide_t'(r_fire), wide_t'(1'b1));

      // random traffic against the model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 3) != 0, $urandom, N'($urandom), r_rdy, r_fire, r_id);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
